me_feeder: RTL and testbench
============================

ME_FEEDER -- requirements
Module: me_feeder

Interface
REQ-001 The block SHALL have no parameters; dimensions are fixed: 8x8 current block, 23x23 search window, 8-bit pixels.
REQ-002 clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 rst_i  input  1  synchronous, active-low reset.
REQ-004 start_i  input  1  one-cycle pulse that starts one block job; ignored while busy_o=1.
REQ-005 busy_o  output  1  high from the cycle after an accepted start_i through the cycle done_o is asserted.
REQ-006 in_valid_i / in_ready_o  input / output  1 / 1  upstream pixel-word handshake; a beat transfers when both are high.
REQ-007 in_data_i  input  64  eight pixels; pixel k in bits [8k+7:8k].
REQ-008 cur_valid_o, cur_row_o, cur_data_o  output  1, 3, 64  one current-block row per pulse, row index 0..7.
REQ-009 ref_valid_o, ref_row_o, ref_data_o  output  1, 5, 184  one 23-pixel search-window row per pulse, row index 0..22; pixel k in bits [8k+7:8k].
REQ-010 done_o  output  1  one-cycle pulse when the job completes.

Function
REQ-011 The FSM SHALL have states IDLE, CUR, REF and DONE.
- IDLE->CUR on start_i; CUR->REF after the 8th CUR beat; REF->DONE after the 69th REF beat; DONE->IDLE after exactly one cycle.
REQ-012 in_ready_o SHALL be 1 exactly in CUR and REF; in IDLE and DONE it SHALL be 0 and in_valid_i is ignored.
REQ-013 CUR: each accepted beat b (0..7) SHALL be registered to cur_data_o with cur_row_o=b and cur_valid_o=1 in the next cycle (latency 1); cur_valid_o=0 otherwise.
REQ-014 REF: beats are grouped in threes per row.
- beat 0 -> pixels 0-7, beat 1 -> pixels 8-15, beat 2 bytes 0-6 -> pixels 16-22.
- beat 2 byte 7 SHALL be discarded.
REQ-015 On acceptance of beat 2 of row r, ref_data_o SHALL present the full row with ref_row_o=r and ref_valid_o=1 in the next cycle; ref_valid_o=0 otherwise.
REQ-016 ref_data_o and cur_data_o SHALL hold their last value when the corresponding valid is 0.
REQ-017 Beat counter (0..2) and row counters (0..7 CUR, 0..22 REF) SHALL advance only on accepted beats; in_valid_i gaps SHALL stall without loss or duplication.
REQ-018 done_o SHALL pulse in the DONE-state cycle, which is the same cycle ref_valid_o presents row 22.
REQ-019 start_i coincident with done_o SHALL be ignored; a new start_i is accepted only in IDLE.
REQ-020 A job SHALL always consist of exactly 8+69=77 accepted beats; no early termination except per REQ-025.

Reset
REQ-021 While rst_i=0 at a clock edge, the block SHALL enter IDLE and clear all counters.
- Outputs SHALL be cleared: busy_o=0, in_ready_o=0, cur_valid_o=0, ref_valid_o=0, done_o=0, cur_row_o=0, ref_row_o=0, cur_data_o=0, ref_data_o=0.
REQ-022 Reset mid-job SHALL abandon the job without done_o; partially assembled ref rows SHALL be discarded.
REQ-023 Reset SHALL take priority over start_i and all beat acceptance.

Configuration
REQ-024 Macro ME_FEEDER_ABORT_EN SHALL control the abort feature.
REQ-025 With ME_FEEDER_ABORT_EN defined, the block SHALL have an input port abort_i (1 bit).
- abort_i=1 in CUR or REF SHALL return the FSM to IDLE next cycle with counters cleared and in_ready_o=0 that cycle.
- done_o SHALL not pulse; a beat coincident with abort_i is not accepted.
- abort_i in IDLE or DONE SHALL have no effect.
REQ-026 Without ME_FEEDER_ABORT_EN, port abort_i SHALL not exist and jobs always run to completion.

Verification
REQ-027 Reset then start_i, 77 back-to-back beats with byte = beat index -> 8 cur pulses rows 0..7, then 23 ref pulses rows 0..22; each pulse 1 cycle after its last beat; done_o with ref row 22; busy_o low after.
REQ-028 REF row of beats 0x0706..00, 0x0F0E..08, 0xFF16151413121110 -> ref_data_o = pixels 0x00..0x16 ascending, 0xFF absent.
REQ-029 in_valid_i toggled randomly (50%) across a full job -> identical output sequence to REQ-027, no missing or duplicate rows.
REQ-030 rst_i=0 asserted after 40 beats -> all outputs 0 next cycle; a fresh job then completes normally with row numbering restarting at 0.
REQ-031 start_i pulsed during CUR and in the done_o cycle -> ignored; exactly one done_o per accepted start.
REQ-032 With ME_FEEDER_ABORT_EN: abort_i at REF row 5 -> IDLE next cycle, no done_o, in_ready_o=0; the next job runs clean.

Source files
------------

// File: rtl/me_feeder.sv
// ============================================================================
// Module      : me_feeder
// Description : Feeds a motion-estimation engine. It loads one 8x8 current
//               block (8 beats) and then one 23x23 search window (69 beats)
//               from a 64-bit pixel stream. Define ME_FEEDER_ABORT_EN to add
//               the abort_i port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module me_feeder (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
`ifdef ME_FEEDER_ABORT_EN
  input  logic         abort_i,
`endif
  output logic         busy_o,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [63:0]  in_data_i,
  output logic         cur_valid_o,
  output logic [2:0]   cur_row_o,
  output logic [63:0]  cur_data_o,
  output logic         ref_valid_o,
  output logic [4:0]   ref_row_o,
  output logic [183:0] ref_data_o,
  output logic         done_o
);

  localparam logic [2:0] c_CUR_LAST  = 3'd7;
  localparam logic [4:0] c_REF_LAST  = 5'd22;
  localparam logic [1:0] c_BEAT_LAST = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CUR  = 2'd1,
    ST_REF  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [2:0]   r_cur_cnt;
  logic [1:0]   r_beat;
  logic [4:0]   r_ref_cnt;
  logic [127:0] r_ref_buf;
  logic         w_abort;
  logic         w_accept;

`ifdef ME_FEEDER_ABORT_EN
  assign w_abort = abort_i && ((r_state == ST_CUR) || (r_state == ST_REF));
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready_o  = 1'b0;
    busy_o      = (r_state != ST_IDLE);
    done_o      = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_nxt = ST_CUR;
      end
      ST_CUR: begin
        // An aborting cycle must not accept a beat.
        in_ready_o = !w_abort;
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (in_valid_i && (r_cur_cnt == c_CUR_LAST)) begin
          w_state_nxt = ST_REF;
        end
      end
      ST_REF: begin
        in_ready_o = !w_abort;
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (in_valid_i && (r_beat == c_BEAT_LAST) && (r_ref_cnt == c_REF_LAST)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_accept = in_valid_i && in_ready_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cur_cnt   <= 3'd0;
      r_beat      <= 2'd0;
      r_ref_cnt   <= 5'd0;
      r_ref_buf   <= 128'd0;
      cur_valid_o <= 1'b0;
      cur_row_o   <= 3'd0;
      cur_data_o  <= 64'd0;
      ref_valid_o <= 1'b0;
      ref_row_o   <= 5'd0;
      ref_data_o  <= 184'd0;
    end else begin
      cur_valid_o <= 1'b0;
      ref_valid_o <= 1'b0;
      if ((r_state == ST_IDLE) || (r_state == ST_DONE) || w_abort) begin
        r_cur_cnt <= 3'd0;
        r_beat    <= 2'd0;
        r_ref_cnt <= 5'd0;
        r_ref_buf <= 128'd0;
      end else if (w_accept && (r_state == ST_CUR)) begin
        cur_valid_o <= 1'b1;
        cur_row_o   <= r_cur_cnt;
        cur_data_o  <= in_data_i;
        r_cur_cnt   <= r_cur_cnt + 3'd1;
      end else if (w_accept && (r_state == ST_REF)) begin
        case (r_beat)
          2'd0: begin
            r_ref_buf[63:0] <= in_data_i;
            r_beat          <= 2'd1;
          end
          2'd1: begin
            r_ref_buf[127:64] <= in_data_i;
            r_beat            <= 2'd2;
          end
          default: begin
            // Byte 7 of the third beat is padding and is dropped here.
            ref_data_o  <= {in_data_i[55:0], r_ref_buf};
            ref_row_o   <= r_ref_cnt;
            ref_valid_o <= 1'b1;
            r_beat      <= 2'd0;
            r_ref_cnt   <= r_ref_cnt + 5'd1;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_me_feeder.sv
// ============================================================================
// Module      : tb_me_feeder
// Description : Self-checking bench for me_feeder (directed vectors, a
//               table of search-window rows and a cycle reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_me_feeder;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
`ifdef ME_FEEDER_ABORT_EN
  logic         abort_i;
`endif
  logic         busy_o;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [63:0]  in_data_i;
  logic         cur_valid_o;
  logic [2:0]   cur_row_o;
  logic [63:0]  cur_data_o;
  logic         ref_valid_o;
  logic [4:0]   ref_row_o;
  logic [183:0] ref_data_o;
  logic         done_o;

  me_feeder u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
`ifdef ME_FEEDER_ABORT_EN
    .abort_i     (abort_i),
`endif
    .busy_o      (busy_o),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .cur_valid_o (cur_valid_o),
    .cur_row_o   (cur_row_o),
    .cur_data_o  (cur_data_o),
    .ref_valid_o (ref_valid_o),
    .ref_row_o   (ref_row_o),
    .ref_data_o  (ref_data_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0]  b0;
    logic [63:0]  b1;
    logic [63:0]  b2;
    logic [183:0] exp;
  } ref_vec_t;

  ref_vec_t tbl [3];

  int n_tot = 0;
  int n_bad = 0;
  int n_cur, n_ref, n_done;
  bit tbl_mode = 1'b0;

  // reference model state (post-edge view)
  int           m_st = 0;
  int           m_idx = 0;
  bit           m_chk = 1'b0;
  logic         m_rdy;
  logic         m_cur_v, m_ref_v;
  logic [2:0]   m_cur_row;
  logic [63:0]  m_cur_data;
  logic [4:0]   m_ref_row;
  logic [183:0] m_ref_data;
  logic [127:0] m_buf;

  task automatic chk(input string name, input logic [183:0] act, input logic [183:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat_data(input int mode, input int idx);
    logic [7:0] b;
    int k;
    if (mode == 2 && idx >= 8 && idx < 17) begin
      k = idx - 8;
      case (k % 3)
        0:       return tbl[k / 3].b0;
        1:       return tbl[k / 3].b1;
        default: return tbl[k / 3].b2;
      endcase
    end
    b = idx[7:0];
    return {8{b}};
  endfunction

  // One clock cycle: check outputs of the last edge, drive new inputs, step the model.
  task automatic tick(input logic rst, input logic s, input logic v, input logic [63:0] d, input logic ab);
    logic acc, m_ab;
    int k;
    @(negedge clk_i);
    if (m_chk) begin
      chk("busy", busy_o, m_st != 0);
      chk("done", done_o, m_st == 3);
      chk("cur_valid", cur_valid_o, m_cur_v);
      chk("ref_valid", ref_valid_o, m_ref_v);
      chk("cur_row", cur_row_o, m_cur_row);
      chk("cur_data", cur_data_o, m_cur_data);
      chk("ref_row", ref_row_o, m_ref_row);
      chk("ref_data", ref_data_o, m_ref_data);
      if (tbl_mode && ref_valid_o && ref_row_o < 5'd3)
        chk("tbl_ref_data", ref_data_o, tbl[int'(ref_row_o)].exp);
      n_cur  += int'(cur_valid_o);
      n_ref  += int'(ref_valid_o);
      n_done += int'(done_o);
    end
    rst_i      = rst;
    start_i    = s;
    in_valid_i = v;
    in_data_i  = d;
`ifdef ME_FEEDER_ABORT_EN
    abort_i = ab;
    m_ab    = ab && (m_st == 1 || m_st == 2);
`else
    m_ab    = 1'b0;
`endif
    #1;
    m_rdy = (m_st == 1 || m_st == 2) && !m_ab;
    if (m_chk) chk("in_ready", in_ready_o, m_rdy);
    acc = v && m_rdy;
    m_cur_v = 1'b0;
    m_ref_v = 1'b0;
    if (!rst) begin
      m_st = 0; m_idx = 0; m_buf = '0;
      m_cur_row = '0; m_cur_data = '0; m_ref_row = '0; m_ref_data = '0;
      m_chk = 1'b1;
    end else begin
      case (m_st)
        0: if (s) begin m_st = 1; m_idx = 0; end
        1: begin
          if (m_ab) m_st = 0;
          else if (acc) begin
            m_cur_v = 1'b1; m_cur_row = m_idx[2:0]; m_cur_data = d;
            m_idx++;
            if (m_idx == 8) m_st = 2;
          end
        end
        2: begin
          if (m_ab) m_st = 0;
          else if (acc) begin
            k = m_idx - 8;
            if (k % 3 == 0) m_buf[63:0] = d;
            else if (k % 3 == 1) m_buf[127:64] = d;
            else begin
              m_ref_v = 1'b1; m_ref_row = 5'(k / 3); m_ref_data = {d[55:0], m_buf};
            end
            m_idx++;
            if (m_idx == 77) m_st = 3;
          end
        end
        default: m_st = 0;
      endcase
    end
  endtask

  // mode: 0 back-to-back, 1 random gaps, 2 table rows, 3 stray starts, 4 reset at beat 40, 5 abort at ref row 5
  task automatic run_job(input int mode, input int exp_cur, input int exp_ref, input int exp_done);
    int cyc;
    logic v, s, a, r;
    n_cur = 0; n_ref = 0; n_done = 0;
    tbl_mode = (mode == 2);
    tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    cyc = 0;
    while (m_st != 0 && cyc < 1000) begin
      v = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      s = (mode == 3) && ((m_st == 1 && m_idx == 3) || m_st == 3);
      a = (mode == 5) && (m_st == 2) && (m_idx == 23);
      r = !((mode == 4) && (m_idx == 40));
      tick(r, s, v, v ? beat_data(mode, m_idx) : 64'hA5A5_5A5A_C3C3_3C3C, a);
      cyc++;
    end
    chk("job_in_time", 1'(cyc < 1000), 1'b1);
    repeat (4) tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    tbl_mode = 1'b0;
    chk("n_cur_pulses", n_cur, exp_cur);
    chk("n_ref_pulses", n_ref, exp_ref);
    chk("n_done_pulses", n_done, exp_done);
    chk("idle_after_job", busy_o, 1'b0);
  endtask

  initial begin
    tbl[0] = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 64'hFF16151413121110,
               184'h16151413121110_0F0E0D0C0B0A0908_0706050403020100};
    tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 64'h00AAAAAAAAAAAAAA,
               184'hAAAAAAAAAAAAAA_0000000000000000_FFFFFFFFFFFFFFFF};
    tbl[2] = '{64'h8877665544332211, 64'h0123456789ABCDEF, 64'h5500000000000001,
               184'h00000000000001_0123456789ABCDEF_8877665544332211};

    rst_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
`ifdef ME_FEEDER_ABORT_EN
    abort_i = 1'b0;
`endif
    repeat (3) tick(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ref_data", ref_data_o, 184'd0);

    run_job(0, 8, 23, 1);
    run_job(1, 8, 23, 1);
    run_job(2, 8, 23, 1);
    run_job(3, 8, 23, 1);
    run_job(4, 8, 10, 0);
    chk("post_rst_cur_data", cur_data_o, 64'd0);
    chk("post_rst_ref_row", ref_row_o, 5'd0);
    run_job(0, 8, 23, 1);
`ifdef ME_FEEDER_ABORT_EN
    run_job(5, 8, 5, 0);
    run_job(0, 8, 23, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
